// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge bus used by the fetch stage.
//   imem_req   : fetch request (fetch stage -> memory)
//   imem_addr  : word-aligned fetch address (fetch stage -> memory)
//   imem_ack   : request completes this cycle (memory -> fetch stage)
//   imem_rdata : instruction word, valid while imem_ack = 1 (memory -> fetch stage)
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage. Owns the fetch address, keeps at most one
// request outstanding on the instruction-memory bus, buffers one fetched
// instruction and presents it to IF/ID as {ia_plus_4, ir}. Follows
// hazard-unit stalls and EX redirects; bubbles are all-zero.
//   clk, rst_n    : clock, asynchronous active-low reset
//   imem          : instruction-memory bus (master side)
//   valid         : from EX, 0 = redirect/flush this cycle
//   target_ia     : from EX, redirect address (low two bits ignored)
//   stall         : from hazard unit, 1 = IF/ID does not latch this cycle
//   id_params_out : {ia_plus_4[31:0], ir[31:0]} to IF/ID
module if_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  if_stage_if.master        imem,
  input  logic              valid,
  input  logic [31:0]       target_ia,
  input  logic              stall,
  output logic [63:0]       id_params_out
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    READY = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_ia_q, buf_ia_d;
  logic [31:0] buf_ir_q, buf_ir_d;
  logic [31:0] out_addr_q, out_addr_d;

  logic        req_s;
  logic [31:0] addr_s;
  logic [63:0] params_s;
  logic        xfer_s;

  // The redirect address is word-aligned, so its two low bits are dropped.
  logic        unused_target_lsb;
  assign unused_target_lsb = &{1'b0, target_ia[1:0]};

  // Bus request, address and IF/ID output for the current state.
  always_comb begin
    req_s    = 1'b0;
    addr_s   = pc_q;
    params_s = 64'd0;
    case (state_q)
      FETCH: begin
        req_s  = 1'b1;
        addr_s = pc_q;
      end
      READY: begin
        // Only state where the request follows stall combinationally.
        req_s    = ~stall;
        addr_s   = pc_q;
        params_s = {buf_ia_q + 32'd4, buf_ir_q};
      end
      DRAIN: begin
        req_s  = 1'b1;
        addr_s = out_addr_q;
      end
      default: begin
        req_s    = 1'b0;
        addr_s   = pc_q;
        params_s = 64'd0;
      end
    endcase
  end

  // The request is forced low while reset is held so the bus is quiet
  // immediately, without waiting for a clock edge.
  assign imem.imem_req  = rst_n & req_s;
  assign imem.imem_addr = addr_s;
  assign id_params_out  = params_s;
  assign xfer_s         = req_s & imem.imem_ack;

  // Next-state, fetch address and instruction buffer update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_ia_d   = buf_ia_q;
    buf_ir_d   = buf_ir_q;
    out_addr_d = out_addr_q;
    if (!valid) begin
      // Redirect wins over stall and over any data returned this cycle.
      pc_d     = {target_ia[31:2], 2'b00};
      buf_ia_d = 32'd0;
      buf_ir_d = 32'd0;
      if (state_q == DRAIN) begin
        state_d = DRAIN;
      end else if (req_s && !imem.imem_ack) begin
        // A request is in flight: finish it at the same address, then drop it.
        out_addr_d = addr_s;
        state_d    = DRAIN;
      end else begin
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (xfer_s) begin
            buf_ir_d = imem.imem_rdata;
            buf_ia_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = READY;
          end else begin
            state_d = FETCH;
          end
        end
        READY: begin
          if (stall) begin
            state_d = READY;
          end else if (xfer_s) begin
            buf_ir_d = imem.imem_rdata;
            buf_ia_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = READY;
          end else begin
            // Request stays up at pc; FETCH keeps it stable until ack.
            state_d = FETCH;
          end
        end
        DRAIN: begin
          if (xfer_s) begin
            state_d = FETCH;
          end else begin
            state_d = DRAIN;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_VECTOR;
      buf_ia_q   <= 32'd0;
      buf_ir_q   <= 32'd0;
      out_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_ia_q   <= buf_ia_d;
      buf_ir_q   <= buf_ir_d;
      out_addr_q <= out_addr_d;
    end
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the MINAv2 pipeline, directly upstream of the IF/ID register. It owns the fetch address, issues one-outstanding request/acknowledge reads to instruction memory, and buffers one fetched instruction. It presents the instruction as an id_params_t (ia_plus_4, ir) to IF/ID. It follows hazard-unit stalls and EX redirects. ir = 0 is the architectural NOP; all bubbles use ia_plus_4 = 0, ir = 0.

Parameters:
RESET_VECTOR, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request
imem_addr  out  32  fetch word address; bits [1:0] always 0
imem_ack  in  1  memory completes the request in this cycle; imem_rdata valid this cycle
imem_rdata  in  32  instruction word
valid  in  1  from EX; 0 = redirect/flush this cycle
target_ia  in  32  from EX; redirect address, used only when valid = 0
stall  in  1  from hazard unit; 1 = IF/ID will not latch this cycle
id_params_out  out  64  id_params_t to IF/ID: {ia_plus_4[31:0], ir[31:0]}

Behaviour:
- Registers:
  - pc: next address to fetch.
  - buf_ia, buf_ir: buffered instruction and its address.
  - out_addr: address of the outstanding request.
  - state: one of FETCH, READY, DRAIN.
- Reset, asynchronous: pc = RESET_VECTOR, state = FETCH, buffer cleared, imem_req = 0, id_params_out = 0. The memory is reset by the same rst_n; any in-flight request is abandoned. The first request is issued in the first cycle after rst_n deasserts.
- A transfer completes on a rising edge where imem_req = 1 and imem_ack = 1. Zero-wait ack in the same cycle as req is legal.
- Once a request is raised without ack, imem_req stays 1 and imem_addr stays stable until ack. There is at most one outstanding request.
- FETCH:
  - Drives imem_req = 1, imem_addr = pc, id_params_out = bubble.
  - On ack: buf_ir <= imem_rdata, buf_ia <= pc, pc <= pc + 4, go to READY.
  - Stall is ignored in FETCH.
- READY:
  - id_params_out = {buf_ia + 4, buf_ir}.
  - Drives imem_req = !stall, imem_addr = pc.
  - stall = 1: hold everything.
  - stall = 0 with ack: buffer reloads from imem_rdata/pc, pc += 4, stay in READY. Throughput is 1 instruction/cycle with zero-wait memory.
  - stall = 0 without ack: go to FETCH; the request continues at the same address.
- DRAIN:
  - Drives imem_req = 1, imem_addr = out_addr, id_params_out = bubble.
  - On ack: the data is discarded, go to FETCH.
- Redirect (valid = 0) takes priority over stall and over ack data:
  - pc <= {target_ia[31:2], 2'b00} and the buffer is invalidated.
  - If imem_req = 1 and imem_ack = 0 this cycle: out_addr <= current imem_addr, go to DRAIN.
  - Otherwise, including when ack arrives in the same cycle: the returned data is discarded, go to FETCH.
  - A redirect while in DRAIN only updates pc; the state stays DRAIN.
- Arithmetic: 32-bit unsigned; pc 32'hFFFF_FFFC + 4 wraps to 0. The ia_plus_4 output equals the address of the instruction + 4, mod 2^32.
- No combinational path from imem_rdata to id_params_out.
- imem_req depends combinationally on stall in READY only.

Test Plan:
1. Reset release, zero-wait memory (ack tied 1), stall = 0 → addresses 0x0, 0x4, 0x8 on consecutive cycles. id_params_out is bubble in cycle 1, then {0x4, mem[0]}, {0x8, mem[1]} back-to-back.
2. Memory with 3-cycle ack latency → imem_addr stays 0x0 and req stays 1 for 3 cycles. The output is bubble until the cycle after ack, then {0x4, mem[0]}; the next request is at 0x4.
3. stall = 1 for 4 cycles while in READY with {0x10, I3} → output holds {0x10, I3}, imem_req = 0, and pc is unchanged. After stall drops, a fetch at 0x10 issues.
4. valid = 0, target_ia = 0x203 while READY → the next request is at 0x200 and the output is bubble. Then {0x204, mem[0x200]}.
5. Redirect to 0x400 while a request at 0x8 is pending without ack → DRAIN holds imem_addr = 0x8 until ack and the data is discarded. The next request is at 0x400, and mem[0x8] never appears on id_params_out.
6. pc = 0xFFFF_FFFC, ack → output ia_plus_4 = 0x0 and the next request is at 0x0. Assert rst_n = 0 mid-request → imem_req = 0 and outputs = 0 immediately, without waiting for a clock edge.
